record_leaderboard: RTL and testbench
=====================================

# record_leaderboard

Parametrised play-record store that keeps up to DEPTH records sorted by score, highest first, and serves reads by rank. It replaces the fixed, unsorted record array with insertion-sorted storage, optional per-(user, chart) de-duplication, and a ready/valid write handshake. It sits beside the chart store and is written by the game-over logic and read by the results/ranking display.

## Interface

**Parameters**
- DEPTH, 8 — number of record slots; must be at least 2.
- USER_W, 8 — user-id width.
- NAME_W, 128 — chart-name width (16 ASCII bytes).
- SCORE_W, 16 — unsigned score width.
- UNIQUE, 1 — 1: at most one entry per (user, name) pair; 0: duplicates allowed.

**Ports**
- clk  in  1  — system clock; all state updates on the rising edge.
- sys_rst_n  in  1  — reset, asynchronous assert, active-low.
- clr  in  1  — synchronous table clear.
- wr_valid  in  1  — insert request.
- wr_ready  out  1  — block can accept an insert (high only in IDLE).
- wr_user  in  USER_W  — user id of the new record.
- wr_name  in  NAME_W  — chart name of the new record.
- wr_score  in  SCORE_W  — score of the new record.
- wr_done  out  1  — one-cycle pulse when an accepted insert resolves.
- wr_drop  out  1  — qualifies wr_done: the record was not stored.
- rd_valid  in  1  — read request.
- rd_rank  in  clog2(DEPTH)  — rank to read; 0 is the highest score.
- rd_resp  out  1  — one-cycle pulse: read data is valid.
- rd_hit  out  1  — rd_rank < count when the request was sampled.
- rd_user, rd_name, rd_score  out  USER_W / NAME_W / SCORE_W  — record read.
- count  out  clog2(DEPTH+1)  — number of occupied slots.

## Operation

- **Storage.** Slots 0..count-1 are valid and non-increasing in score. Slots at or above count hold zero.
- **FSM states:** IDLE, FIND, COMMIT.
  - **IDLE.** wr_ready=1. On wr_valid, latch the request and go to FIND.
  - **FIND.** Register three results:
    - pos: the first slot whose score is strictly below wr_score, or count if there is none. Ties therefore insert after equal scores (stable ordering).
    - dup: when UNIQUE=1, the index of the existing slot with equal user and name.
    - drop decision (next bullet).
    Then go to COMMIT.
  - **COMMIT.** Apply the change, pulse wr_done (and wr_drop if dropped), return to IDLE.
- **Drop rules:**
  - UNIQUE=1 and a duplicate exists with score ≥ wr_score → drop.
  - No duplicate, count==DEPTH, and pos==DEPTH → drop.
- **Commit actions:**
  - Duplicate found, dup ≥ pos: shift slots pos..dup-1 down by one, write the new record at pos. count is unchanged.
  - No duplicate: shift slots pos..DEPTH-2 down by one (the old slot DEPTH-1 is evicted when full), write at pos. count increments, saturating at DEPTH.
- **Reads.** Sampled whenever rd_valid=1, in any FSM state.
  - Response is registered: rd_resp, rd_hit and data appear the cycle after.
  - Miss (rd_rank ≥ count): rd_hit=0 and the data outputs are 0.
  - Read and COMMIT on the same edge: the read returns the pre-commit contents.
  - The data outputs hold their value between responses.
- **clr.** Has highest priority: all slots zeroed, count=0, FSM forced to IDLE. An in-flight insert is aborted and produces no wr_done. A read sampled with clr returns rd_resp=1, rd_hit=0.
- **Widths.** Score comparison is unsigned at SCORE_W; no arithmetic on scores.

## Timing

- **Reset (sys_rst_n=0), asynchronous:** all slots 0, count=0, FSM=IDLE, wr_ready=1, and wr_done, wr_drop, rd_resp, rd_hit, rd_user, rd_name, rd_score all 0.
- wr_ready is decoded combinationally from the FSM state.
- **Insert latency:** accept at edge T; FIND resolves at T+1; COMMIT at T+2. wr_done is high in the cycle after T+2, and wr_ready returns to 1 in that same cycle. Throughput is one insert per 3 cycles.
- wr_valid asserted while wr_ready=0 is ignored; the source must hold the request.
- **Read latency:** 1 cycle; a new read may be issued every cycle.
- **Reset mid-operation:** asynchronous return to reset state; nothing partial is retained.

## Test plan

1. Reset, then read rank 0 → rd_resp=1, rd_hit=0, rd_score=0; count=0; wr_ready=1.
2. Insert scores 500, 900, 700 (distinct users) → each wr_done arrives 3 cycles after accept with wr_drop=0; count=3; ranks 0/1/2 read 900/700/500.
3. DEPTH=8 full with scores 800..100 in steps of 100:
   - insert 50 → wr_drop=1, contents unchanged;
   - insert 450 → stored at rank 4, score 100 evicted, count stays 8.
4. UNIQUE=1, user 2 "Little Stars" at 300:
   - reinsert with 250 → dropped;
   - reinsert with 600 → single entry for the pair at the rank of 600; count unchanged.
5. Tie handling: insert user 1 with 400, then user 2 with 400 → rank 0 is user 1, rank 1 is user 2.
6. Assert clr on the FIND cycle of an insert → no wr_done, count=0, next read has rd_hit=0. A read issued on the COMMIT edge returns the old data.

Source files
------------

// File: rtl/record_leaderboard.sv
// Score-sorted record table, highest score first, with optional per-(user, name) de-duplication.
// An insert is accepted in IDLE, searched in FIND, and applied in COMMIT. Reads are registered and served by rank.
module record_leaderboard #(
  parameter int DEPTH   = 8,
  parameter int USER_W  = 8,
  parameter int NAME_W  = 128,
  parameter int SCORE_W = 16,
  parameter int UNIQUE  = 1,
  localparam int RW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic               clr,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [USER_W-1:0]  wr_user,
  input  logic [NAME_W-1:0]  wr_name,
  input  logic [SCORE_W-1:0] wr_score,
  output logic               wr_done,
  output logic               wr_drop,
  input  logic               rd_valid,
  input  logic [RW-1:0]      rd_rank,
  output logic               rd_resp,
  output logic               rd_hit,
  output logic [USER_W-1:0]  rd_user,
  output logic [NAME_W-1:0]  rd_name,
  output logic [SCORE_W-1:0] rd_score,
  output logic [CW-1:0]      count
);
  typedef enum logic [1:0] {IDLE, FIND, COMMIT} state_t;
  state_t state, state_nxt;

  logic [USER_W-1:0]  user_q  [DEPTH];
  logic [NAME_W-1:0]  name_q  [DEPTH];
  logic [SCORE_W-1:0] score_q [DEPTH];
  logic [CW-1:0]      count_q;

  logic [USER_W-1:0]  req_user;
  logic [NAME_W-1:0]  req_name;
  logic [SCORE_W-1:0] req_score;

  logic [CW-1:0] pos_c, pos_q;
  logic [RW-1:0] dup_c, dup_q;
  logic          dup_hit_c, dup_hit_q;
  logic          drop_c, drop_q;

  assign count = count_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) state_nxt = FIND;
      end
      FIND:    state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Scanning high-to-low leaves pos at the first slot scoring strictly below the request.
  // Equal scores therefore keep their place ahead of the newcomer.
  always_comb begin
    pos_c     = count_q;
    dup_hit_c = 1'b0;
    dup_c     = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (CW'(i) < count_q && score_q[i] < req_score) pos_c = CW'(i);
    for (int i = 0; i < DEPTH; i++)
      if (UNIQUE != 0 && CW'(i) < count_q && user_q[i] == req_user && name_q[i] == req_name) begin
        dup_hit_c = 1'b1;
        dup_c     = RW'(i);
      end
    if (dup_hit_c) drop_c = (score_q[dup_c] >= req_score);
    else           drop_c = (count_q == CW'(DEPTH)) && (pos_c == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_user  <= '0;
      req_name  <= '0;
      req_score <= '0;
      pos_q     <= '0;
      dup_q     <= '0;
      dup_hit_q <= 1'b0;
      drop_q    <= 1'b0;
    end else if (!clr) begin
      if (state == IDLE && wr_valid) begin
        req_user  <= wr_user;
        req_name  <= wr_name;
        req_score <= wr_score;
      end
      if (state == FIND) begin
        pos_q     <= pos_c;
        dup_q     <= dup_c;
        dup_hit_q <= dup_hit_c;
        drop_q    <= drop_c;
      end
    end
  end

  // The shift stops at the old duplicate slot, or runs to the end of the table and evicts the last entry.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        user_q[i]  <= '0;
        name_q[i]  <= '0;
        score_q[i] <= '0;
      end
      count_q <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        user_q[i]  <= '0;
        name_q[i]  <= '0;
        score_q[i] <= '0;
      end
      count_q <= '0;
    end else if (state == COMMIT && !drop_q) begin
      for (int i = 1; i < DEPTH; i++)
        if (CW'(i) > pos_q && (!dup_hit_q || RW'(i) <= dup_q)) begin
          user_q[i]  <= user_q[i-1];
          name_q[i]  <= name_q[i-1];
          score_q[i] <= score_q[i-1];
        end
      for (int i = 0; i < DEPTH; i++)
        if (CW'(i) == pos_q) begin
          user_q[i]  <= req_user;
          name_q[i]  <= req_name;
          score_q[i] <= req_score;
        end
      if (!dup_hit_q && count_q != CW'(DEPTH)) count_q <= count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_done <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_done <= (state == COMMIT) && !clr;
      wr_drop <= (state == COMMIT) && !clr && drop_q;
    end
  end

  // Reads see the table as it stood before this edge, so a read on the COMMIT edge returns the old contents.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_resp  <= 1'b0;
      rd_hit   <= 1'b0;
      rd_user  <= '0;
      rd_name  <= '0;
      rd_score <= '0;
    end else begin
      rd_resp <= rd_valid;
      if (rd_valid) begin
        if (!clr && CW'(rd_rank) < count_q) begin
          rd_hit   <= 1'b1;
          rd_user  <= user_q[rd_rank];
          rd_name  <= name_q[rd_rank];
          rd_score <= score_q[rd_rank];
        end else begin
          rd_hit   <= 1'b0;
          rd_user  <= '0;
          rd_name  <= '0;
          rd_score <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_record_leaderboard.sv
// Scoreboard bench for record_leaderboard. A list-based leaderboard model predicts every wr_done and read response.
// A negedge monitor pops those predictions and compares them against the DUT.
module tb_record_leaderboard;
  localparam int DEPTH = 8, USER_W = 8, NAME_W = 128, SCORE_W = 16, UNIQUE = 1;

  logic               clk = 1'b0, sys_rst_n, clr, wr_valid, wr_ready, wr_done, wr_drop;
  logic [USER_W-1:0]  wr_user, rd_user;
  logic [NAME_W-1:0]  wr_name, rd_name;
  logic [SCORE_W-1:0] wr_score, rd_score;
  logic               rd_valid, rd_resp, rd_hit;
  logic [2:0]         rd_rank;
  logic [3:0]         count;

  record_leaderboard #(.DEPTH(DEPTH), .USER_W(USER_W), .NAME_W(NAME_W), .SCORE_W(SCORE_W), .UNIQUE(UNIQUE)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .clr(clr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_user(wr_user), .wr_name(wr_name), .wr_score(wr_score),
    .wr_done(wr_done), .wr_drop(wr_drop),
    .rd_valid(rd_valid), .rd_rank(rd_rank), .rd_resp(rd_resp), .rd_hit(rd_hit),
    .rd_user(rd_user), .rd_name(rd_name), .rd_score(rd_score), .count(count));

  always #5 clk = ~clk;

  typedef struct {logic [USER_W-1:0] user; logic [NAME_W-1:0] name; logic [SCORE_W-1:0] score;} rec_t;
  typedef struct {bit drop; int cyc;} wexp_t;
  typedef struct {bit hit; rec_t r;} rexp_t;

  rec_t  model[$], view[$];
  wexp_t exp_wr[$];
  rexp_t exp_rd[$];
  int vectors = 0, errors = 0, cyc = 0;
  logic [NAME_W-1:0] names [3];

  always @(posedge clk) cyc <= cyc + 1;

  // Leaderboard as a sorted list: drop a weaker repeat, replace a stronger one, and insert after equal scores.
  function automatic bit model_insert(input rec_t r);
    int d, p;
    d = -1;
    for (int i = 0; i < model.size(); i++)
      if (UNIQUE != 0 && model[i].user == r.user && model[i].name == r.name) d = i;
    if (d >= 0) begin
      if (model[d].score >= r.score) return 1'b1;
      model.delete(d);
    end
    p = model.size();
    for (int i = model.size() - 1; i >= 0; i--)
      if (model[i].score < r.score) p = i;
    if (d < 0 && model.size() == DEPTH && p == DEPTH) return 1'b1;
    model.insert(p, r);
    if (model.size() > DEPTH) model.delete(DEPTH);
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitor
  logic [USER_W-1:0]  last_user;
  logic [NAME_W-1:0]  last_name;
  logic [SCORE_W-1:0] last_score;
  always @(negedge clk) begin : monitor
    wexp_t w;
    rexp_t e;
    if (!sys_rst_n) begin
      last_user = '0; last_name = '0; last_score = '0;
    end else begin
      if (wr_done) begin
        vectors++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_done_unexpected: got wr_done=1 drop=%0b, want no pulse", wr_drop);
        end else begin
          w = exp_wr.pop_front();
          if (wr_drop !== w.drop || cyc != w.cyc) begin
            errors++;
            $display("FAIL wr_done: got drop=%0b cyc=%0d want drop=%0b cyc=%0d", wr_drop, cyc, w.drop, w.cyc);
          end
        end
      end else begin
        chk("wr_drop_alone", wr_drop, 0);
      end
      if (rd_resp) begin
        vectors++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_resp_unexpected: got rd_resp=1, want none pending");
        end else begin
          e = exp_rd.pop_front();
          if (rd_hit !== e.hit || rd_user !== e.r.user || rd_name !== e.r.name || rd_score !== e.r.score) begin
            errors++;
            $display("FAIL rd_data: got hit=%0b user=%0h name=%0h score=%0d want hit=%0b user=%0h name=%0h score=%0d",
                     rd_hit, rd_user, rd_name, rd_score, e.hit, e.r.user, e.r.name, e.r.score);
          end
        end
        last_user = rd_user; last_name = rd_name; last_score = rd_score;
      end else begin
        chk("rd_hold_score", rd_score, last_score);
        chk("rd_hold_user", {rd_user, rd_name}, {last_user, last_name});
      end
    end
  end

  // Driver helpers: every task is entered and left at a falling edge.
  task automatic issue_read(input int rank, input bit clr_now);
    rexp_t e;
    rd_valid = 1'b1;
    rd_rank  = 3'(rank);
    e.hit = !clr_now && rank < view.size();
    if (e.hit) e.r = view[rank];
    else begin e.r.user = '0; e.r.name = '0; e.r.score = '0; end
    exp_rd.push_back(e);
  endtask

  task automatic step_read(input int mode);
    if (mode == 2) issue_read(0, 1'b0);
    else if (mode == 1 && $urandom_range(0, 1) == 1) issue_read($urandom_range(0, DEPTH - 1), 1'b0);
    else rd_valid = 1'b0;
  endtask

  task automatic do_insert(input int u, input logic [NAME_W-1:0] n, input int s, input int mode);
    rec_t  r;
    wexp_t w;
    r.user = USER_W'(u); r.name = n; r.score = SCORE_W'(s);
    chk("wr_ready_idle", wr_ready, 1);
    wr_valid = 1'b1; wr_user = r.user; wr_name = r.name; wr_score = r.score;
    view = model;
    w.drop = model_insert(r);
    w.cyc  = cyc + 3;
    exp_wr.push_back(w);
    step_read(mode); @(negedge clk);
    wr_valid = 1'b0;
    step_read(mode); @(negedge clk);
    step_read(mode); @(negedge clk);
    rd_valid = 1'b0;
    view = model;
    chk("count_after_insert", count, model.size());
  endtask

  task automatic idle(input int n);
    repeat (n) begin step_read(1); @(negedge clk); end
    rd_valid = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin issue_read(i, 1'b0); @(negedge clk); end
    rd_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; rd_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    model.delete(); view = model;
    chk("count_after_clr", count, 0);
  endtask

  initial begin
    names[0] = "Little Stars"; names[1] = "Moon Walker"; names[2] = "Red Sunrise";
    sys_rst_n = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_user = '0; wr_name = '0; wr_score = '0;
    rd_valid = 1'b0; rd_rank = '0;
    repeat (2) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_wr_done", {wr_done, wr_drop}, 0);
    chk("rst_rd", {rd_resp, rd_hit, rd_score}, 0);
    sys_rst_n = 1'b1;
    @(negedge clk);
    issue_read(0, 1'b0); @(negedge clk); rd_valid = 1'b0;

    do_insert(10, names[1], 500, 0);
    do_insert(11, names[1], 900, 0);
    do_insert(12, names[1], 700, 0);
    chk("count_three", count, 3);
    read_all();

    do_clr();
    for (int k = 0; k < 8; k++) do_insert(20 + k, names[1], 800 - 100 * k, 0);
    do_insert(30, names[1], 50, 1);
    read_all();
    do_insert(31, names[1], 450, 1);
    chk("count_full", count, 8);
    read_all();

    do_clr();
    do_insert(1, names[0], 1000, 0);
    do_insert(2, names[0], 300, 0);
    do_insert(3, names[2], 700, 0);
    do_insert(2, names[0], 250, 1);
    do_insert(2, names[0], 600, 1);
    chk("count_dup", count, 3);
    read_all();

    do_clr();
    do_insert(1, names[2], 400, 0);
    do_insert(2, names[2], 400, 0);
    read_all();

    // A read on every edge of this insert, including the COMMIT edge, must see the old table.
    do_insert(5, names[1], 900, 2);
    read_all();
    wr_valid = 1'b1; wr_user = 8'd6; wr_name = names[0]; wr_score = 16'd100; rd_valid = 1'b0;
    @(negedge clk);
    wr_valid = 1'b0; clr = 1'b1; view = model;
    issue_read(0, 1'b1);
    @(negedge clk);
    clr = 1'b0; rd_valid = 1'b0;
    model.delete(); view = model;
    chk("count_clr_find", count, 0);
    idle(4);
    issue_read(0, 1'b0); @(negedge clk); rd_valid = 1'b0;

    for (int it = 0; it < 250; it++) begin
      int k;
      k = $urandom_range(0, 19);
      if (k == 0) do_clr();
      else if (k < 4) idle($urandom_range(1, 3));
      else do_insert($urandom_range(0, 5), names[$urandom_range(0, 2)], $urandom_range(0, 20) * 50, 1);
    end
    read_all();

    wr_valid = 1'b1; wr_user = 8'd9; wr_name = names[2]; wr_score = 16'd123; rd_valid = 1'b0;
    @(negedge clk);
    wr_valid = 1'b0;
    #2 sys_rst_n = 1'b0;
    @(negedge clk);
    #2 sys_rst_n = 1'b1;
    @(negedge clk);
    model.delete(); view = model;
    chk("count_after_reset", count, 0);
    chk("ready_after_reset", wr_ready, 1);
    idle(3);
    read_all();

    repeat (3) @(negedge clk);
    chk("pending_wr", exp_wr.size(), 0);
    chk("pending_rd", exp_rd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
